// File: rtl/sc_datapath_sequencer.sv
// Microprogram sequencer driving the uDATAPATH control buses: ACC = FIX0 * FIX1, then ACC -> shifter (+ optional shifts).
// Latency: done pulses 2*FIX1 + 6 + SHIFT_STEPS cycles after the start-sample edge; outputs are Moore-decoded from state.
// Backpressure: none; start is only sampled in IDLE/ERROR and ignored while busy.
//
// Ports:
//   SC_DPCTRL_CLOCK_50 / SC_DPCTRL_RESET_InLow       clock, async active-low reset
//   SC_DPCTRL_start_In                               start request
//   SC_DPCTRL_{overflow,carry,negative,zero}_InLow   active-low ALU flags for the current cycle
//   decoder clear/load, bus A/B mux, ALU select      datapath control buses
//   regSHIFTER clear/load (active-low), shift mode   shift-register controls
//   busy / done / error                              status
module sc_datapath_sequencer #(
  parameter int DATAWIDTH_DECODER_SELECTION    = 4,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_NOP = {DATAWIDTH_DECODER_SELECTION{1'b1}},
  parameter int REG_ACC  = 0,
  parameter int REG_CNT  = 1,
  parameter int MUX_FIX0 = 6,
  parameter int MUX_FIX1 = 7,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_PASSA = DATAWIDTH_ALU_SELECTION'(0),
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ADD   = DATAWIDTH_ALU_SELECTION'(1),
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_DECA  = DATAWIDTH_ALU_SELECTION'(2),
  parameter int SHIFT_STEPS = 0,
  parameter logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SHIFT_DIR = DATAWIDTH_REGSHIFTER_SELECTION'(1),
  parameter int MAX_ITER = 255
) (
  input  logic                                      SC_DPCTRL_CLOCK_50,
  input  logic                                      SC_DPCTRL_RESET_InLow,
  input  logic                                      SC_DPCTRL_start_In,
  input  logic                                      SC_DPCTRL_overflow_InLow,
  input  logic                                      SC_DPCTRL_carry_InLow,
  input  logic                                      SC_DPCTRL_negative_InLow,
  input  logic                                      SC_DPCTRL_zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DPCTRL_decoderclearselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DPCTRL_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DPCTRL_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DPCTRL_muxselectionBUSB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DPCTRL_aluselection_OutBUS,
  output logic                                      SC_DPCTRL_regSHIFTERclear_OutLow,
  output logic                                      SC_DPCTRL_regSHIFTERload_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DPCTRL_regSHIFTERshiftselection_OutLow,
  output logic                                      SC_DPCTRL_busy_Out,
  output logic                                      SC_DPCTRL_done_Out,
  output logic                                      SC_DPCTRL_error_Out
);

  localparam int ITER_W = (MAX_ITER < 2) ? 1 : $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam logic [1:0] LAST_STEP = (SHIFT_STEPS > 0) ? 2'(SHIFT_STEPS - 1) : 2'd0;

  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_ACC = DATAWIDTH_DECODER_SELECTION'(REG_ACC);
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEC_CNT = DATAWIDTH_DECODER_SELECTION'(REG_CNT);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_ACC = DATAWIDTH_MUX_SELECTION'(REG_ACC);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_CNT = DATAWIDTH_MUX_SELECTION'(REG_CNT);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_F0  = DATAWIDTH_MUX_SELECTION'(MUX_FIX0);
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_F1  = DATAWIDTH_MUX_SELECTION'(MUX_FIX1);

  typedef enum logic [3:0] {
    IDLE, CLR_ACC, CLR_CNT, LD_CNT, ADD, DEC, CLR_SH, LD_SH, SHIFT, DONE, ERROR
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [ITER_W-1:0] iterCnt;
  logic [1:0]        stepCnt;

  // The carry flag carries no meaning for this microprogram.
  logic unusedCarry;
  assign unusedCarry = SC_DPCTRL_carry_InLow;

  always_ff @(posedge SC_DPCTRL_CLOCK_50 or negedge SC_DPCTRL_RESET_InLow) begin
    if (!SC_DPCTRL_RESET_InLow) begin
      state   <= IDLE;
      iterCnt <= '0;
      stepCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == CLR_CNT)
        iterCnt <= '0;
      else if (state == ADD)
        iterCnt <= iterCnt + 1'b1;
      // Step counter only runs while shifting, so it is zero on SHIFT entry.
      if (state == SHIFT)
        stepCnt <= stepCnt + 2'd1;
      else
        stepCnt <= '0;
    end
  end

  always_comb begin
    stateNext = state;
    SC_DPCTRL_decoderclearselection_OutBUS    = DEC_NOP;
    SC_DPCTRL_decoderloadselection_OutBUS     = DEC_NOP;
    SC_DPCTRL_muxselectionBUSA_OutBUS         = '0;
    SC_DPCTRL_muxselectionBUSB_OutBUS         = '0;
    SC_DPCTRL_aluselection_OutBUS             = ALU_PASSA;
    SC_DPCTRL_regSHIFTERclear_OutLow          = 1'b1;
    SC_DPCTRL_regSHIFTERload_OutLow           = 1'b1;
    SC_DPCTRL_regSHIFTERshiftselection_OutLow = '0;
    SC_DPCTRL_busy_Out                        = 1'b0;
    SC_DPCTRL_done_Out                        = 1'b0;
    SC_DPCTRL_error_Out                       = 1'b0;

    unique case (state)
      IDLE: begin
        if (SC_DPCTRL_start_In) stateNext = CLR_ACC;
      end
      CLR_ACC: begin
        SC_DPCTRL_busy_Out = 1'b1;
        SC_DPCTRL_decoderclearselection_OutBUS = DEC_ACC;
        stateNext = CLR_CNT;
      end
      CLR_CNT: begin
        SC_DPCTRL_busy_Out = 1'b1;
        SC_DPCTRL_decoderclearselection_OutBUS = DEC_CNT;
        stateNext = LD_CNT;
      end
      LD_CNT: begin
        SC_DPCTRL_busy_Out = 1'b1;
        SC_DPCTRL_muxselectionBUSA_OutBUS = MUX_F1;
        SC_DPCTRL_decoderloadselection_OutBUS = DEC_CNT;
        // Zero multiplier: skip the add/decrement loop entirely.
        stateNext = SC_DPCTRL_zero_InLow ? ADD : CLR_SH;
      end
      ADD: begin
        SC_DPCTRL_busy_Out = 1'b1;
        SC_DPCTRL_muxselectionBUSA_OutBUS = MUX_ACC;
        SC_DPCTRL_muxselectionBUSB_OutBUS = MUX_F0;
        SC_DPCTRL_aluselection_OutBUS = ALU_ADD;
        SC_DPCTRL_decoderloadselection_OutBUS = DEC_ACC;
        stateNext = SC_DPCTRL_overflow_InLow ? DEC : ERROR;
      end
      DEC: begin
        SC_DPCTRL_busy_Out = 1'b1;
        SC_DPCTRL_muxselectionBUSA_OutBUS = MUX_CNT;
        SC_DPCTRL_aluselection_OutBUS = ALU_DECA;
        SC_DPCTRL_decoderloadselection_OutBUS = DEC_CNT;
        // Flags describe the decremented count being written back this cycle.
        if (!SC_DPCTRL_negative_InLow)  stateNext = ERROR;
        else if (!SC_DPCTRL_zero_InLow) stateNext = CLR_SH;
        else if (iterCnt == ITER_LIMIT) stateNext = ERROR;
        else                            stateNext = ADD;
      end
      CLR_SH: begin
        SC_DPCTRL_busy_Out = 1'b1;
        SC_DPCTRL_regSHIFTERclear_OutLow = 1'b0;
        stateNext = LD_SH;
      end
      LD_SH: begin
        SC_DPCTRL_busy_Out = 1'b1;
        SC_DPCTRL_muxselectionBUSA_OutBUS = MUX_ACC;
        SC_DPCTRL_regSHIFTERload_OutLow = 1'b0;
        stateNext = (SHIFT_STEPS == 0) ? DONE : SHIFT;
      end
      SHIFT: begin
        SC_DPCTRL_busy_Out = 1'b1;
        SC_DPCTRL_regSHIFTERshiftselection_OutLow = SHIFT_DIR;
        if (stepCnt == LAST_STEP) stateNext = DONE;
      end
      DONE: begin
        SC_DPCTRL_done_Out = 1'b1;
        stateNext = IDLE;
      end
      ERROR: begin
        SC_DPCTRL_error_Out = 1'b1;
        if (SC_DPCTRL_start_In) stateNext = CLR_ACC;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sc_datapath_sequencer.sv
// Directed bench: two sequencer instances (default params; MAX_ITER=4/SHIFT_STEPS=2) each wired to a small datapath model.
// Latency and shifter contents are compared against hand-computed values.
// Start is driven on falling edges; outputs are sampled on falling edges.
module tb_sc_datapath_sequencer;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nBad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] aluRes(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      4'd1:    aluRes = a + b;
      4'd2:    aluRes = a - 32'd1;
      default: aluRes = a;
    endcase
  endfunction

  function automatic logic aluOvf(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = aluRes(sel, a, b);
    aluOvf = (sel == 4'd1) && (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic [31:0] muxV(input logic [2:0] code, input logic [31:0] acc, input logic [31:0] cnt,
                                       input logic [31:0] f0, input logic [31:0] f1);
    case (code)
      3'd0:    muxV = acc;
      3'd1:    muxV = cnt;
      3'd6:    muxV = f0;
      3'd7:    muxV = f1;
      default: muxV = 32'd0;
    endcase
  endfunction

  // ---------------- instance A: default parameters ----------------
  logic        startA = 1'b0;
  logic [3:0]  clrA, ldA, aluA;
  logic [2:0]  muxAA, muxBA;
  logic        shClrA, shLdA, busyA, doneA, errA;
  logic [1:0]  shModeA;
  logic [31:0] accA = 0, cntA = 0, shA = 0, fix0A = 0, fix1A = 0;
  logic [31:0] busAA, busBA, resA;

  assign busAA = muxV(muxAA, accA, cntA, fix0A, fix1A);
  assign busBA = muxV(muxBA, accA, cntA, fix0A, fix1A);
  assign resA  = aluRes(aluA, busAA, busBA);

  sc_datapath_sequencer dutA (
    .SC_DPCTRL_CLOCK_50                        (clk),
    .SC_DPCTRL_RESET_InLow                     (rstN),
    .SC_DPCTRL_start_In                        (startA),
    .SC_DPCTRL_overflow_InLow                  (~aluOvf(aluA, busAA, busBA)),
    .SC_DPCTRL_carry_InLow                     (1'b1),
    .SC_DPCTRL_negative_InLow                  (~resA[31]),
    .SC_DPCTRL_zero_InLow                      (resA != 32'd0),
    .SC_DPCTRL_decoderclearselection_OutBUS    (clrA),
    .SC_DPCTRL_decoderloadselection_OutBUS     (ldA),
    .SC_DPCTRL_muxselectionBUSA_OutBUS         (muxAA),
    .SC_DPCTRL_muxselectionBUSB_OutBUS         (muxBA),
    .SC_DPCTRL_aluselection_OutBUS             (aluA),
    .SC_DPCTRL_regSHIFTERclear_OutLow          (shClrA),
    .SC_DPCTRL_regSHIFTERload_OutLow           (shLdA),
    .SC_DPCTRL_regSHIFTERshiftselection_OutLow (shModeA),
    .SC_DPCTRL_busy_Out                        (busyA),
    .SC_DPCTRL_done_Out                        (doneA),
    .SC_DPCTRL_error_Out                       (errA)
  );

  always @(posedge clk) begin
    if (clrA == 4'd0) accA <= 0;
    if (clrA == 4'd1) cntA <= 0;
    if (ldA == 4'd0)  accA <= resA;
    if (ldA == 4'd1)  cntA <= resA;
    if (!shClrA)                shA <= 0;
    else if (!shLdA)            shA <= resA;
    else if (shModeA == 2'b01)  shA <= shA << 1;
    else if (shModeA == 2'b10)  shA <= shA >> 1;
  end

  // ---------------- instance B: MAX_ITER=4, SHIFT_STEPS=2 ----------------
  logic        startB = 1'b0;
  logic [3:0]  clrB, ldB, aluB;
  logic [2:0]  muxAB, muxBB;
  logic        shClrB, shLdB, busyB, doneB, errB;
  logic [1:0]  shModeB;
  logic [31:0] accB = 0, cntB = 0, shB = 0, fix0B = 0, fix1B = 0;
  logic [31:0] busAB, busBB, resB;

  assign busAB = muxV(muxAB, accB, cntB, fix0B, fix1B);
  assign busBB = muxV(muxBB, accB, cntB, fix0B, fix1B);
  assign resB  = aluRes(aluB, busAB, busBB);

  sc_datapath_sequencer #(.MAX_ITER(4), .SHIFT_STEPS(2), .SHIFT_DIR(2'b01)) dutB (
    .SC_DPCTRL_CLOCK_50                        (clk),
    .SC_DPCTRL_RESET_InLow                     (rstN),
    .SC_DPCTRL_start_In                        (startB),
    .SC_DPCTRL_overflow_InLow                  (~aluOvf(aluB, busAB, busBB)),
    .SC_DPCTRL_carry_InLow                     (1'b1),
    .SC_DPCTRL_negative_InLow                  (~resB[31]),
    .SC_DPCTRL_zero_InLow                      (resB != 32'd0),
    .SC_DPCTRL_decoderclearselection_OutBUS    (clrB),
    .SC_DPCTRL_decoderloadselection_OutBUS     (ldB),
    .SC_DPCTRL_muxselectionBUSA_OutBUS         (muxAB),
    .SC_DPCTRL_muxselectionBUSB_OutBUS         (muxBB),
    .SC_DPCTRL_aluselection_OutBUS             (aluB),
    .SC_DPCTRL_regSHIFTERclear_OutLow          (shClrB),
    .SC_DPCTRL_regSHIFTERload_OutLow           (shLdB),
    .SC_DPCTRL_regSHIFTERshiftselection_OutLow (shModeB),
    .SC_DPCTRL_busy_Out                        (busyB),
    .SC_DPCTRL_done_Out                        (doneB),
    .SC_DPCTRL_error_Out                       (errB)
  );

  always @(posedge clk) begin
    if (clrB == 4'd0) accB <= 0;
    if (clrB == 4'd1) cntB <= 0;
    if (ldB == 4'd0)  accB <= resB;
    if (ldB == 4'd1)  cntB <= resB;
    if (!shClrB)                shB <= 0;
    else if (!shLdB)            shB <= resB;
    else if (shModeB == 2'b01)  shB <= shB << 1;
    else if (shModeB == 2'b10)  shB <= shB >> 1;
  end

  // Clear and load decoders must never both select a register in one cycle.
  always @(negedge clk) begin
    check("clr_ld_excl_A", (clrA != 4'hF) && (ldA != 4'hF), 0);
    check("clr_ld_excl_B", (clrB != 4'hF) && (ldB != 4'hF), 0);
  end

  task automatic setStart(input bit inst, input logic v);
    if (inst) startB = v;
    else      startA = v;
  endtask

  // Pulses start, then samples each cycle (k = 1 is the first cycle after the start-sample edge).
  // A stray start pulse at k=5 must be ignored. Returns at the falling edge where done or error appears.
  task automatic runSeq(input bit inst, input logic [31:0] f0, input logic [31:0] f1,
                        output int lat, output int errAt, output int adds, output logic [31:0] shOut);
    if (inst) begin fix0B = f0; fix1B = f1; end
    else      begin fix0A = f0; fix1A = f1; end
    lat = -1; errAt = -1; adds = 0; shOut = 32'hDEAD_BEEF;
    @(negedge clk);
    setStart(inst, 1'b1);
    @(negedge clk);
    setStart(inst, 1'b0);
    for (int k = 1; k <= 600 && lat < 0 && errAt < 0; k++) begin
      if (k == 5) setStart(inst, 1'b1);
      if (k == 6) setStart(inst, 1'b0);
      if ((inst ? aluB : aluA) == 4'd1) adds++;
      if (inst ? doneB : doneA) begin lat = k; shOut = inst ? shB : shA; end
      if (inst ? errB : errA) errAt = k;
      if (lat < 0 && errAt < 0) @(negedge clk);
    end
    setStart(inst, 1'b0);
  endtask

  task automatic checkIdleOutputsA(input string tag);
    check({tag, "_clr"},  clrA, 4'hF);
    check({tag, "_ld"},   ldA, 4'hF);
    check({tag, "_mux"},  {muxAA, muxBA}, 0);
    check({tag, "_alu"},  aluA, 0);
    check({tag, "_shcl"}, {shClrA, shLdA, shModeA}, 4'b1100);
    check({tag, "_stat"}, {busyA, doneA, errA}, 0);
  endtask

  int lat, errAt, adds;
  logic [31:0] shOut;
  bit seen;

  initial begin
    #1;
    checkIdleOutputsA("reset");
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    // 9 * 15, no shift
    runSeq(1'b0, 32'd9, 32'd15, lat, errAt, adds, shOut);
    check("mul_lat", lat, 36);
    check("mul_err", errAt, -1);
    check("mul_adds", adds, 15);
    check("mul_sh", shOut, 135);
    check("mul_busy_at_done", busyA, 0);
    @(negedge clk);
    check("done_one_cycle", {doneA, busyA}, 0);

    // FIX1 = 0 skips the loop
    runSeq(1'b0, 32'd9, 32'd0, lat, errAt, adds, shOut);
    check("zero_lat", lat, 6);
    check("zero_adds", adds, 0);
    check("zero_sh", shOut, 0);

    // overflow in the second ADD
    runSeq(1'b0, 32'h7FFF_FFFF, 32'd3, lat, errAt, adds, shOut);
    check("ovf_errAt", errAt, 7);
    check("ovf_nodone", lat, -1);
    check("ovf_adds", adds, 2);
    repeat (3) @(negedge clk);
    check("ovf_hold", {errA, busyA, doneA}, 3'b100);
    runSeq(1'b0, 32'd9, 32'd15, lat, errAt, adds, shOut);
    check("ovf_restart_lat", lat, 36);
    check("ovf_restart_sh", shOut, 135);
    check("ovf_restart_err", errA, 0);

    // watchdog: MAX_ITER = 4
    runSeq(1'b1, 32'd9, 32'd15, lat, errAt, adds, shOut);
    check("wd_errAt", errAt, 12);
    check("wd_adds", adds, 4);
    check("wd_nodone", lat, -1);

    // two left shifts after load: 27 << 2
    runSeq(1'b1, 32'd9, 32'd3, lat, errAt, adds, shOut);
    check("shift_lat", lat, 14);
    check("shift_sh", shOut, 108);
    check("shift_err", errB, 0);

    // reset in the middle of the loop
    fix0A = 32'd9; fix1A = 32'd15;
    @(negedge clk); startA = 1'b1;
    @(negedge clk); startA = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busyA, 1);
    #2 rstN = 1'b0;
    #1 checkIdleOutputsA("midrst");
    @(negedge clk); rstN = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (doneA || errA || busyA) seen = 1;
    end
    check("midrst_quiet", seen, 0);
    runSeq(1'b0, 32'd9, 32'd15, lat, errAt, adds, shOut);
    check("post_rst_lat", lat, 36);
    check("post_rst_sh", shOut, 135);

    // start held high through DONE: one IDLE cycle, then a fresh run
    fix0A = 32'd9; fix1A = 32'd0;
    @(negedge clk); startA = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = doneA;
    end
    check("held_done", seen, 1);
    @(negedge clk);
    check("held_idle", {busyA, doneA}, 0);
    @(negedge clk);
    check("held_restart", busyA, 1);
    startA = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = doneA;
    end
    check("held_second_done", seen, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
